// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//   LED sequencer with a programmable-period step timer and four runtime
//   selectable patterns: rotate left, rotate right, bounce and fill/clear.
//
//   Optional build macro: LED_PWM_EN
//     When defined, the design adds a 4-bit duty input and a free-running
//     4-bit PWM counter that gates the LED outputs. The step timing and the
//     pattern logic do not change.
//
// Parameters
//   NUM_LEDS   number of LED outputs (>= 2)
//   SHIFT_TIME clock cycles per pattern step (>= 1)
//   CNT_W      step counter width, 2**CNT_W > SHIFT_TIME
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous reset, active-high, priority over all inputs
//   en    in   run enable; low freezes timer, pattern and mode
//   mode  in   00 rotate left, 01 rotate right, 10 bounce, 11 fill/clear
//   duty  in   (LED_PWM_EN only) PWM duty, 0..15 of 16 cycles lit
//   led   out  LED drive, bit 0 = LED0
//   step  out  registered one-cycle pulse, coincident with each led update
module led_pattern_engine #(
    parameter int NUM_LEDS   = 8,
    parameter int SHIFT_TIME = 50000000,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
`ifdef LED_PWM_EN
    input  logic [3:0]          duty,
`endif
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0]    TERM_CNT = CNT_W'(SHIFT_TIME - 1);
    localparam logic [NUM_LEDS-1:0] LED_INIT = NUM_LEDS'(1);

    logic [CNT_W-1:0]    cnt_q,  cnt_d;
    logic [NUM_LEDS-1:0] led_q,  led_d;
    logic                step_q, step_d;
    dir_e                dir_q,  dir_d;
    logic                fill_q, fill_d;
    logic [1:0]          mode_q, mode_d;

    logic [NUM_LEDS-1:0] rot_l;
    logic [NUM_LEDS-1:0] rot_r;
    logic [NUM_LEDS-1:0] fill_shift;

    always_comb begin
        rot_l      = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
        rot_r      = {led_q[0], led_q[NUM_LEDS-1:1]};
        fill_shift = {led_q[NUM_LEDS-2:0], ~fill_q};
    end

    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        fill_d = fill_q;
        mode_d = mode_q;

        if (en) begin
            if (cnt_q == TERM_CNT) begin
                cnt_d  = '0;
                step_d = 1'b1;
                if (mode != mode_q) begin
                    // A mode change restarts the pattern instead of advancing it.
                    mode_d = mode;
                    led_d  = LED_INIT;
                    dir_d  = DIR_UP;
                    fill_d = 1'b0;
                end else begin
                    case (mode_q)
                        2'b00: led_d = rot_l;
                        2'b01: led_d = rot_r;
                        2'b10: begin
                            // Reverse while leaving an endpoint so each end
                            // is shown for exactly one step.
                            if (dir_q == DIR_UP) begin
                                if (led_q[NUM_LEDS-1]) begin
                                    led_d = led_q >> 1;
                                    dir_d = DIR_DOWN;
                                end else begin
                                    led_d = led_q << 1;
                                end
                            end else begin
                                if (led_q[0]) begin
                                    led_d = led_q << 1;
                                    dir_d = DIR_UP;
                                end else begin
                                    led_d = led_q >> 1;
                                end
                            end
                        end
                        2'b11: begin
                            led_d = fill_shift;
                            if ((!fill_q && (&fill_shift)) || (fill_q && !(|fill_shift)))
                                fill_d = ~fill_q;
                        end
                        default: led_d = led_q;
                    endcase
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            led_q  <= LED_INIT;
            step_q <= 1'b0;
            dir_q  <= DIR_UP;
            fill_q <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            step_q <= step_d;
            dir_q  <= dir_d;
            fill_q <= fill_d;
            mode_q <= mode_d;
        end
    end

    assign step = step_q;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;

    // Free-running brightness counter, independent of en.
    always_comb pwm_cnt_d = pwm_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt_q <= 4'd0;
        else     pwm_cnt_q <= pwm_cnt_d;
    end

    assign led = led_q & {NUM_LEDS{pwm_cnt_q < duty}};
`else
    assign led = led_q;
`endif

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised LED sequencer driving NUM_LEDS outputs from a programmable-period step timer.
- Four runtime-selectable patterns: rotate left, rotate right, bounce, fill/clear.
- Adds an enable input and a step strobe.
- Sits at top level between the board clock and the LED pins; the step strobe is available to other blocks for synchronisation.

Parameters:
- NUM_LEDS, 8, number of LED outputs; legal range ≥2.
- SHIFT_TIME, 50000000, clock cycles per pattern step; legal range ≥1.
- CNT_W, 32, step-counter width; must satisfy 2^CNT_W > SHIFT_TIME.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; low freezes the timer and pattern.
- mode  in  2  pattern select: 00 rotate left, 01 rotate right, 10 bounce, 11 fill/clear.
- led  out  NUM_LEDS  LED drive, bit 0 = LED0.
- step  out  1  one-cycle pulse, registered, coincident with each pattern update.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst. rst has priority over all other inputs.
- Reset values: led = 1 (LED0 only lit), counter = 0, step = 0, dir = up, fill_phase = 0 (filling), mode_q = 00.
- Timer, en=1: counter increments each cycle. When counter == SHIFT_TIME-1, counter goes to 0 and a step occurs on that edge.
- Step period: exactly SHIFT_TIME cycles. With SHIFT_TIME=1, a step occurs every enabled cycle.
- Timer, en=0: counter, led, dir, fill_phase and mode_q all hold; step = 0. On re-enable, the count resumes from the held value (no restart).
- step: high for exactly the cycle following a step edge, i.e. the same cycle the new led value appears. Latency from terminal count to both updates is 1 clock.
- Mode sampling: mode is sampled only at step edges.
  - If mode != mode_q at a step: mode_q <= mode, led <= 1, dir <= up, fill_phase <= 0. No advance happens on that step.
  - Otherwise the pattern advances per mode_q.
- Rotate left (00): led <= {led[N-2:0], led[N-1]}.
- Rotate right (01): led <= {led[0], led[N-1:1]}.
- Bounce (10): a single lit bit moves up while dir=up. On reaching bit N-1 it reverses; on reaching bit 0 it reverses again.
  - Each endpoint is displayed for one step only.
  - N=4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
- Fill/clear (11): led <= {led[N-2:0], ~fill_phase}.
  - fill_phase toggles when the shift result is all ones (while filling) or all zeros (while clearing).
  - N=4 sequence: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001, …
- Reset mid-step: rst in any cycle forces the reset values on the next edge. The timer restarts from 0 and the first step occurs SHIFT_TIME enabled cycles after rst deasserts.
- Every reachable state is legal, so there are no illegal states. Bounce mode keeps exactly one bit set.

Optional Feature:
- Macro LED_PWM_EN.
- When defined:
  - Adds input port duty (in, 4 bits) and a free-running 4-bit pwm_cnt (reset 0, increments every cycle regardless of en).
  - led = led_q & {NUM_LEDS{pwm_cnt < duty}}.
  - duty=0 gives all LEDs dark; duty=8 gives 50% on.
  - step and the pattern logic are unaffected.
- When undefined: no duty port, no pwm_cnt; led = led_q directly.

Test Plan:
- Reset and rotate left: NUM_LEDS=4, SHIFT_TIME=4, mode=00, en=1, rst for 2 cycles → led=0001. Then 0010, 0100, 1000, 0001 appear every 4 cycles, each with a one-cycle step pulse.
- Rotate right and mode change: run mode=00 to led=0100, then set mode=01 → the next step gives led=0001 with no advance. Following steps give 1000, 0100.
- Bounce endpoints: mode=10 from reset over 8 steps → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Endpoints are never repeated.
- Fill/clear wrap: mode=11 from reset over 9 steps → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
- Enable hold and midway reset:
  - Drop en at counter=2 for 10 cycles → led and step frozen; next step arrives 2 enabled cycles after en returns.
  - Assert rst mid-count → led=0001 and counter=0 next cycle.
- PWM, with LED_PWM_EN defined: duty=4, led_q=0001 → led[0] high for 4 of every 16 cycles. duty=0 → led=0 always.
